// File: rtl/hb_up2_pkg.sv
// Shared helpers for hb_up2_tdm: latency and accumulator width functions, default coefficients.
package hb_up2_pkg;

  typedef logic signed [15:0] coe_t;

  localparam int unsigned DefNumCoe = 5;

  typedef coe_t coe_arr_t [DefNumCoe];

  // c[0] is the outermost tap; c[K-1] sits next to the centre tap.
  localparam coe_arr_t DefCoeNums = '{16'sh01dc, 16'shfcdb, 16'sh0609, 16'shf3c6, 16'sh2847};

  function automatic int unsigned hb_up2_lat(input int unsigned k);
    return 3 + $clog2(k);
  endfunction

  function automatic int unsigned acc_width(input int unsigned xw, input int unsigned cw,
                                            input int unsigned k);
    return xw + cw + 1 + $clog2(k);
  endfunction

endpackage

// File: rtl/hb_adder_tree.sv
// Pipelined signed adder tree: N inputs, one register per level, $clog2(N) levels.
module hb_adder_tree #(
  parameter int unsigned N = 5,
  parameter int unsigned W = 16,
  localparam int unsigned Lvls = $clog2(N),
  localparam int unsigned OW = W + Lvls
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic signed [W-1:0]  din [N],
  output logic signed [OW-1:0] dout
);

  // Zero padding to 2N keeps every pair index in range at every level.
  logic signed [OW-1:0] ext [2*N];

  always_comb begin
    for (int j = 0; j < 2 * N; j++) ext[j] = '0;
    for (int j = 0; j < N; j++) ext[j] = OW'(din[j]);
  end

  if (Lvls == 0) begin : g_pass
    assign dout = ext[0];
  end else begin : g_tree
    logic signed [OW-1:0] stg [Lvls][2*N];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int l = 0; l < Lvls; l++) begin
          for (int j = 0; j < 2 * N; j++) stg[l][j] <= '0;
        end
      end else begin
        for (int j = 0; j < N; j++) stg[0][j] <= ext[2*j] + ext[2*j+1];
        for (int l = 1; l < Lvls; l++) begin
          for (int j = 0; j < N; j++) stg[l][j] <= stg[l-1][2*j] + stg[l-1][2*j+1];
        end
      end
    end

    assign dout = stg[Lvls-1][0];
  end

endmodule

// File: rtl/hb_up2_tdm.sv
// TDM half-band interpolate-by-2 filter. Optional saturation of yout1 under HB_UP2_TDM_SAT_EN;
// without it yout1 wraps. Pipeline: pre-add, multiply, adder tree, round/shift/limit.
module hb_up2_tdm
  import hb_up2_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned XIN_WIDTH = 16,
  parameter int unsigned COE_WIDTH = 16,
  parameter int unsigned NUM_UNIQUE_COE = 5,
  parameter logic signed [COE_WIDTH-1:0] COE_NUMS [NUM_UNIQUE_COE] = DefCoeNums,
  parameter int unsigned YOUT_WIDTH = 16,
  parameter int unsigned SRA_BITS = 15,
  localparam int unsigned CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [XIN_WIDTH-1:0]  xin,
  input  logic                  xin_valid,
  input  logic                  xin_first,
  output logic [YOUT_WIDTH-1:0] yout0,
  output logic [YOUT_WIDTH-1:0] yout1,
  output logic                  yout_valid,
  output logic [CW-1:0]         yout_ch,
  output logic                  ovf
);

  localparam int unsigned K = NUM_UNIQUE_COE;
  localparam int unsigned Taps = 2 * K;
  localparam int unsigned TreeLvls = $clog2(K);
  localparam int unsigned PW = XIN_WIDTH + 1;
  localparam int unsigned MW = PW + COE_WIDTH;
  localparam int unsigned AW = acc_width(XIN_WIDTH, COE_WIDTH, K);
  localparam int unsigned SW = (AW + 1 > YOUT_WIDTH) ? AW + 1 : YOUT_WIDTH + 1;
  localparam bit NoOvf = (YOUT_WIDTH + SRA_BITS >= AW);
  localparam int unsigned RndSh = (SRA_BITS > 0) ? SRA_BITS - 1 : 0;
  localparam logic signed [SW-1:0] RndC = (SRA_BITS > 0) ? (SW'(1) << RndSh) : '0;

  logic [CW-1:0]                ch_q, cur_ch;
  logic signed [XIN_WIDTH-1:0]  hist_q [NUM_CH][Taps-1];
  logic signed [XIN_WIDTH-1:0]  tap [Taps];

  logic signed [PW-1:0]         s1_pre [K];
  logic signed [XIN_WIDTH-1:0]  s1_y0;
  logic [CW-1:0]                s1_ch;
  logic                         s1_vld;
  logic signed [MW-1:0]         s2_prod [K];
  logic signed [XIN_WIDTH-1:0]  sb_y0 [TreeLvls+1];
  logic [CW-1:0]                sb_ch [TreeLvls+1];
  logic                         sb_vld [TreeLvls+1];
  logic signed [AW-1:0]         acc;

  logic signed [SW-1:0]         rnd, shifted;
  logic                         fits, ovf_c;
  logic [YOUT_WIDTH-1:0]        y1_c;

  assign cur_ch = xin_first ? '0 : ch_q;

  always_comb begin
    tap[0] = xin;
    for (int j = 1; j < Taps; j++) tap[j] = hist_q[cur_ch][j-1];
  end

  // Per-channel history so a resync via xin_first keeps each channel's samples separate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        for (int j = 0; j < Taps - 1; j++) hist_q[c][j] <= '0;
      end
    end else if (xin_valid) begin
      ch_q <= (cur_ch == CW'(NUM_CH - 1)) ? '0 : cur_ch + 1'b1;
      hist_q[cur_ch][0] <= xin;
      for (int j = 1; j < Taps - 1; j++) hist_q[cur_ch][j] <= hist_q[cur_ch][j-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < K; i++) begin
        s1_pre[i]  <= '0;
        s2_prod[i] <= '0;
      end
      s1_y0  <= '0;
      s1_ch  <= '0;
      s1_vld <= 1'b0;
      for (int l = 0; l <= TreeLvls; l++) begin
        sb_y0[l]  <= '0;
        sb_ch[l]  <= '0;
        sb_vld[l] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < K; i++) begin
        s1_pre[i]  <= PW'(tap[i]) + PW'(tap[Taps-1-i]);
        s2_prod[i] <= MW'(s1_pre[i]) * MW'(COE_NUMS[i]);
      end
      s1_y0     <= tap[K];
      s1_ch     <= cur_ch;
      s1_vld    <= xin_valid;
      sb_y0[0]  <= s1_y0;
      sb_ch[0]  <= s1_ch;
      sb_vld[0] <= s1_vld;
      for (int l = 1; l <= TreeLvls; l++) begin
        sb_y0[l]  <= sb_y0[l-1];
        sb_ch[l]  <= sb_ch[l-1];
        sb_vld[l] <= sb_vld[l-1];
      end
    end
  end

  hb_adder_tree #(
    .N (K),
    .W (MW)
  ) u_tree (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (s2_prod),
    .dout  (acc)
  );

  always_comb begin
    rnd     = SW'(acc) + RndC;
    shifted = rnd >>> SRA_BITS;
    fits    = (&shifted[SW-1:YOUT_WIDTH-1]) | ~(|shifted[SW-1:YOUT_WIDTH-1]);
    ovf_c   = NoOvf ? 1'b0 : ~fits;
    y1_c    = shifted[YOUT_WIDTH-1:0];
`ifdef HB_UP2_TDM_SAT_EN
    if (ovf_c) begin
      y1_c = shifted[SW-1] ? {1'b1, {(YOUT_WIDTH-1){1'b0}}} : {1'b0, {(YOUT_WIDTH-1){1'b1}}};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      yout0      <= '0;
      yout1      <= '0;
      yout_valid <= 1'b0;
      yout_ch    <= '0;
      ovf        <= 1'b0;
    end else begin
      yout_valid <= sb_vld[TreeLvls];
      if (sb_vld[TreeLvls]) begin
        yout0   <= YOUT_WIDTH'(sb_y0[TreeLvls]);
        yout1   <= y1_c;
        yout_ch <= sb_ch[TreeLvls];
        ovf     <= ovf_c;
      end
    end
  end

endmodule

// File: tb/tb_hb_up2_tdm.sv
// Scoreboard bench for hb_up2_tdm: a 16-bit and a 10-bit output instance share one stimulus.
module tb_hb_up2_tdm;

  typedef struct {
    int ch;
    int y0;
    int y1;
    int cyc;
  } exp_t;

  localparam int Lat = 6;
  const int Coe[5] = '{476, -805, 1545, -3130, 10311};
  const int ImpY1[10] = '{238, -402, 773, -1565, 5156, 5156, -1565, 773, -402, 238};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] xin = '0;
  logic        xin_valid = 1'b0;
  logic        xin_first = 1'b0;
  logic [15:0] yout0, yout1;
  logic        yout_valid, ovf;
  logic [1:0]  yout_ch;
  logic [9:0]  yout0_n, yout1_n;
  logic        yout_valid_n, ovf_n;
  logic [1:0]  yout_ch_n;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int bch = 0;
  int hist[4][10];
  exp_t sbq[$];
  exp_t mon_e;
  int mon_y;
  bit mon_o;

  hb_up2_tdm dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .xin        (xin),
    .xin_valid  (xin_valid),
    .xin_first  (xin_first),
    .yout0      (yout0),
    .yout1      (yout1),
    .yout_valid (yout_valid),
    .yout_ch    (yout_ch),
    .ovf        (ovf)
  );

  hb_up2_tdm #(
    .YOUT_WIDTH (10)
  ) dut_n (
    .clk        (clk),
    .rst_n      (rst_n),
    .xin        (xin),
    .xin_valid  (xin_valid),
    .xin_first  (xin_first),
    .yout0      (yout0_n),
    .yout1      (yout1_n),
    .yout_valid (yout_valid_n),
    .yout_ch    (yout_ch_n),
    .ovf        (ovf_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic void lim(input int v, input int yw, output int y, output bit o);
    int mx = (1 << (yw - 1)) - 1;
    int mn = -(1 << (yw - 1));
    int m = 1 << yw;
    o = (v > mx) || (v < mn);
`ifdef HB_UP2_TDM_SAT_EN
    y = (v > mx) ? mx : ((v < mn) ? mn : v);
`else
    y = v & (m - 1);
    if (y > mx) y -= m;
`endif
  endfunction

  always @(negedge clk) begin
    if (rst_n && yout_valid) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_valid: output with empty scoreboard at cycle %0d", cyc);
      end else begin
        mon_e = sbq.pop_front();
        chk("latency", cyc - mon_e.cyc, Lat);
        chk("ch", yout_ch, mon_e.ch);
        chk("y0", longint'($signed(yout0)), mon_e.y0);
        lim(mon_e.y1, 16, mon_y, mon_o);
        chk("y1", longint'($signed(yout1)), mon_y);
        chk("ovf", ovf, mon_o);
        lim(mon_e.y1, 10, mon_y, mon_o);
        chk("n_valid", yout_valid_n, 1);
        chk("n_ch", yout_ch_n, mon_e.ch);
        chk("n_y1", longint'($signed(yout1_n)), mon_y);
        chk("n_ovf", ovf_n, mon_o);
      end
    end
  end

  task automatic issue(input int x, input bit first, input bit hand, input int hy0,
                       input int hy1);
    exp_t e;
    int c;
    longint acc;
    @(posedge clk);
    #1;
    xin = 16'(x);
    xin_first = first;
    xin_valid = 1'b1;
    c = first ? 0 : bch;
    bch = (c + 1) % 4;
    for (int j = 9; j > 0; j--) hist[c][j] = hist[c][j-1];
    hist[c][0] = x;
    e.ch = c;
    e.cyc = cyc;
    if (hand) begin
      e.y0 = hy0;
      e.y1 = hy1;
    end else begin
      acc = 0;
      for (int i = 0; i < 5; i++) acc += longint'(Coe[i]) * (hist[c][i] + hist[c][9-i]);
      e.y1 = int'((acc + 16384) >>> 15);
      e.y0 = hist[c][5];
    end
    sbq.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      xin_valid = 1'b0;
      xin_first = 1'b0;
    end
  endtask

  task automatic rand_x(output int x);
    logic signed [15:0] r16;
    r16 = 16'($urandom);
    x = int'(r16);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_y0"}, yout0, 0);
    chk({tag, "_y1"}, yout1, 0);
    chk({tag, "_valid"}, yout_valid, 0);
    chk({tag, "_ch"}, yout_ch, 0);
    chk({tag, "_ovf"}, ovf, 0);
    chk({tag, "_n_y1"}, yout1_n, 0);
    chk({tag, "_n_valid"}, yout_valid_n, 0);
  endtask

  task automatic model_reset();
    sbq.delete();
    bch = 0;
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 10; j++) hist[c][j] = 0;
    end
  endtask

  task automatic impulse_run();
    for (int r = 0; r < 12; r++) begin
      for (int c = 0; c < 4; c++) begin
        issue((c == 0 && r == 0) ? 16384 : 0, (c == 0 && r == 0), 1'b1,
              (c == 0 && r == 5) ? 16384 : 0, (c == 0 && r < 10) ? ImpY1[r] : 0);
      end
    end
    idle(1);
  endtask

  initial begin
    int x;
    model_reset();
    #12;
    check_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(3);

    // Impulse on ch0.
    impulse_run();
    idle(8);

    // DC 1000 on ch2, others 0; settled outputs after 10 ch2 samples.
    for (int r = 0; r < 12; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (c == 2 && r >= 9) issue(1000, 1'b0, 1'b1, 1000, 513);
        else issue((c == 2) ? 1000 : 0, (r == 0 && c == 0), 1'b0, 0, 0);
      end
    end
    idle(8);

    // Sparse random input: one sample every third clock.
    for (int n = 0; n < 24; n++) begin
      rand_x(x);
      issue(x, 1'b0, 1'b0, 0, 0);
      idle(2);
    end
    idle(8);

    // Resync: xin_first on what would be the ch2 sample.
    rand_x(x);
    issue(x, 1'b1, 1'b0, 0, 0);
    rand_x(x);
    issue(x, 1'b0, 1'b0, 0, 0);
    for (int n = 0; n < 14; n++) begin
      rand_x(x);
      issue(x, (n == 0), 1'b0, 0, 0);
    end
    idle(8);

    // Reset mid-stream, then the impulse must reproduce with no stale history.
    for (int n = 0; n < 7; n++) begin
      rand_x(x);
      issue(x, 1'b0, 1'b0, 0, 0);
    end
    @(posedge clk);
    #1;
    xin_valid = 1'b0;
    xin_first = 1'b0;
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);
    impulse_run();

    for (int i = 0; i < 30 && sbq.size() != 0; i++) @(posedge clk);
    #2;
    chk("drain_pending", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
